// File: rtl/mips_defs.sv
// Shared MIPS definitions for the multiply/divide unit: funct codes, the FSM state type
// and the HI/LO result record.
package mips_defs;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, MUL, DIV} mdu_state_t;

    // wr=0 marks a result that must not touch HI/LO (divide by zero).
    typedef struct packed {
        logic        wr;
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_res_t;

endpackage

// File: rtl/mul_div_unit.sv
// Multiply/divide unit owning HI/LO. Results are computed at accept into staging registers
// and committed after a fixed latency; EX is stalled while an operation is in flight.
module mul_div_unit
    import mips_defs::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [5:0]  funct,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    mdu_res_t         stg_q;
    mdu_res_t         res_d;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             accept;

    function automatic mdu_res_t multiply(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return '{wr: 1'b1, hi: p[63:32], lo: p[31:0]};
    endfunction

    // Signed divide goes through magnitudes so 0x80000000/-1 wraps to 0x80000000 rem 0.
    function automatic mdu_res_t divide(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return '0;
        ua = (sgn && a[31]) ? -a : a;
        ub = (sgn && b[31]) ? -b : b;
        q  = ua / ub;
        r  = ua % ub;
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31])           r = -r;
        return '{wr: 1'b1, hi: r, lo: q};
    endfunction

    always_comb begin
        res_d = '0;
        case (funct)
            FUNCT_MULT:  res_d = multiply(src_a, src_b, 1'b1);
            FUNCT_MULTU: res_d = multiply(src_a, src_b, 1'b0);
            FUNCT_DIV:   res_d = divide(src_a, src_b, 1'b1);
            FUNCT_DIVU:  res_d = divide(src_a, src_b, 1'b0);
            default:     res_d = '0;
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign accept = op_valid && !busy;
    assign stall  = op_valid && busy;
    assign hi     = hi_q;
    assign lo     = lo_q;

    always_comb begin
        rd_data = 32'd0;
        if (funct == FUNCT_MFHI)      rd_data = hi_q;
        else if (funct == FUNCT_MFLO) rd_data = lo_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stg_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (funct)
                            FUNCT_MULT, FUNCT_MULTU: begin
                                if (MUL_CYCLES == 1) begin
                                    if (res_d.wr) begin
                                        hi_q <= res_d.hi;
                                        lo_q <= res_d.lo;
                                    end
                                end else begin
                                    state_q <= MUL;
                                    cnt_q   <= CNT_W'(MUL_CYCLES - 1);
                                    stg_q   <= res_d;
                                end
                            end
                            FUNCT_DIV, FUNCT_DIVU: begin
                                if (DIV_CYCLES == 1) begin
                                    if (res_d.wr) begin
                                        hi_q <= res_d.hi;
                                        lo_q <= res_d.lo;
                                    end
                                end else begin
                                    state_q <= DIV;
                                    cnt_q   <= CNT_W'(DIV_CYCLES - 1);
                                    stg_q   <= res_d;
                                end
                            end
                            FUNCT_MTHI: hi_q <= src_a;
                            FUNCT_MTLO: lo_q <= src_a;
                            default: ;
                        endcase
                    end
                end
                // The edge that takes the counter to zero is the commit edge.
                MUL, DIV: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        if (stg_q.wr) begin
                            hi_q <= stg_q.hi;
                            lo_q <= stg_q.lo;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a vector table of MDU operations plus hand-written
// sequences for stalls, divide by zero, asynchronous reset and back-to-back issue.
module tb_mul_div_unit;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        stall;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total = 0;
    int n_pass  = 0;

    mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .funct(funct),
        .src_a(src_a), .src_b(src_b), .busy(busy), .stall(stall),
        .rd_data(rd_data), .hi(hi), .lo(lo)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_busy;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single accept edge, then count the busy cycles that follow.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy);
        op_valid = 1'b1;
        funct    = f;
        src_a    = a;
        src_b    = b;
        step();
        op_valid = 1'b0;
        funct    = 6'd0;
        nbusy    = 0;
        while (busy && nbusy < 40) begin
            nbusy++;
            step();
        end
    endtask

    task automatic read_back(input string name, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
        op_valid = 1'b1;
        funct    = FUNCT_MFHI;
        #1;
        check({name, " mfhi"}, rd_data, exp_hi);
        funct = FUNCT_MFLO;
        #1;
        check({name, " mflo"}, rd_data, exp_lo);
        op_valid = 1'b0;
        funct    = 6'd0;
    endtask

    initial begin
        int nb;
        int guard;

        vecs[0] = '{"mult_neg",   FUNCT_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 4};
        vecs[1] = '{"multu_ff2",  FUNCT_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 4};
        vecs[2] = '{"mult_max",   FUNCT_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 4};
        vecs[3] = '{"multu_ffff", FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4};
        vecs[4] = '{"div_neg7",   FUNCT_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 9};
        vecs[5] = '{"divu_7_2",   FUNCT_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 9};
        vecs[6] = '{"div_7_m2",   FUNCT_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 9};
        vecs[7] = '{"div_ovf",    FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 9};
        vecs[8] = '{"divu_big",   FUNCT_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 9};

        rst_n    = 1'b0;
        op_valid = 1'b0;
        funct    = 6'd0;
        src_a    = 32'd0;
        src_b    = 32'd0;
        step();
        step();
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, nb);
            check({vecs[i].name, " busy_cycles"}, nb, vecs[i].exp_busy);
            check({vecs[i].name, " hi"}, hi, vecs[i].exp_hi);
            check({vecs[i].name, " lo"}, lo, vecs[i].exp_lo);
            read_back(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo);
            step();
        end

        // MFHI held in EX while a MULTU is in flight.
        op_valid = 1'b1; funct = FUNCT_MULTU; src_a = 32'hFFFFFFFF; src_b = 32'd2;
        step();
        funct = FUNCT_MFHI;
        #1;
        guard = 0;
        while (busy && guard < 40) begin
            check("mfhi_hold stall", {31'd0, stall}, 32'd1);
            guard++;
            step();
        end
        check("mfhi_hold cycles", guard, 32'd4);
        check("mfhi_hold stall_after", {31'd0, stall}, 32'd0);
        check("mfhi_hold rd_data", rd_data, 32'd1);
        op_valid = 1'b0;
        step();

        // Divide by zero keeps the full busy period but leaves HI/LO alone.
        run_op(FUNCT_MTHI, 32'h1234, 32'd0, nb);
        run_op(FUNCT_MTLO, 32'h5678, 32'd0, nb);
        check("mt hi", hi, 32'h1234);
        check("mt lo", lo, 32'h5678);
        run_op(FUNCT_DIV, 32'd99, 32'd0, nb);
        check("div0 busy_cycles", nb, 32'd9);
        check("div0 hi", hi, 32'h1234);
        check("div0 lo", lo, 32'h5678);

        // Ignored funct changes nothing.
        run_op(6'b100000, 32'hDEAD, 32'hBEEF, nb);
        check("ign busy", nb, 32'd0);
        check("ign hi", hi, 32'h1234);
        check("ign lo", lo, 32'h5678);

        // Asynchronous reset in the middle of a MULT.
        op_valid = 1'b1; funct = FUNCT_MULT; src_a = 32'd6; src_b = 32'd7;
        step();
        op_valid = 1'b0;
        step();
        check("pre_rst busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst busy", {31'd0, busy}, 32'd0);
        check("async_rst hi", hi, 32'd0);
        check("async_rst lo", lo, 32'd0);
        #1;
        rst_n    = 1'b1;
        op_valid = 1'b1; funct = FUNCT_MTLO; src_a = 32'hAA;
        step();
        op_valid = 1'b0;
        check("post_rst lo", lo, 32'hAA);
        check("post_rst hi", hi, 32'd0);
        check("post_rst busy", {31'd0, busy}, 32'd0);
        step();
        step();
        check("post_rst no_commit lo", lo, 32'hAA);

        // MULT then DIV back to back with op_valid held.
        op_valid = 1'b1; funct = FUNCT_MULT; src_a = 32'd5; src_b = 32'hFFFFFFFD;
        step();
        funct = FUNCT_DIV; src_a = 32'd100; src_b = 32'd7;
        #1;
        guard = 0;
        while (busy && guard < 40) begin
            check("b2b stall_eq_busy", {31'd0, stall}, {31'd0, busy});
            guard++;
            step();
        end
        check("b2b mul_cycles", guard, 32'd4);
        check("b2b stall_free", {31'd0, stall}, 32'd0);
        check("b2b mul hi", hi, 32'hFFFFFFFF);
        check("b2b mul lo", lo, 32'hFFFFFFF1);
        step();
        check("b2b div accepted", {31'd0, busy}, 32'd1);
        check("b2b div stall", {31'd0, stall}, 32'd1);
        op_valid = 1'b0;
        guard = 0;
        while (busy && guard < 40) begin
            guard++;
            step();
        end
        check("b2b div_cycles", guard, 32'd9);
        check("b2b div hi", hi, 32'd2);
        check("b2b div lo", lo, 32'd14);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
